// File: rtl/mem_port_arbiter.sv
// Arbitrates the single processor-memory port between instruction fetch and the LS unit,
// tracking one outstanding tagged load per requester and returning registered done/data pulses.
module mem_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MEM_TAG_W    = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 ls_req,
  input  logic                 ls_read_write,
  input  logic [XLEN-1:0]      ls_addr,
  input  logic [XLEN-1:0]      ls_wdata,
  input  logic [1:0]           ls_size,
  output logic                 ls_grant,
  output logic                 ls_done,
  output logic [XLEN-1:0]      ls_rdata,
  input  logic                 if_req,
  input  logic [XLEN-1:0]      if_addr,
  output logic                 if_grant,
  output logic                 if_done,
  output logic [XLEN-1:0]      if_rdata,
  output logic [1:0]           proc2mem_command,
  output logic [XLEN-1:0]      proc2mem_addr,
  output logic [XLEN-1:0]      proc2mem_data,
  output logic [1:0]           proc2mem_size,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [XLEN-1:0]      mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0]  CMD_NONE  = 2'd0;
  localparam logic [1:0]  CMD_LOAD  = 2'd1;
  localparam logic [1:0]  CMD_STORE = 2'd2;
  localparam logic [1:0]  SIZE_WORD = 2'd2;

  logic                 ls_pend, if_pend;
  logic [MEM_TAG_W-1:0] ls_tag, if_tag;
  logic [STREAK_W-1:0]  streak;

  logic ls_elig, if_elig, sel_ls, sel_if, accepted;
  logic ls_ret, if_ret;

  // Selection, grant and memory command; reset forces the port idle.
  always_comb begin
    ls_elig          = ls_req && !ls_pend;
    if_elig          = if_req && !if_pend;
    sel_if           = reset && if_elig && (!ls_elig || streak == STREAK_W'(STARVE_LIMIT));
    sel_ls           = reset && ls_elig && !sel_if;
    accepted         = mem2proc_response != '0;
    ls_grant         = sel_ls && accepted;
    if_grant         = sel_if && accepted;
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (sel_if) begin
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = if_addr;
      proc2mem_size    = SIZE_WORD;
    end else if (sel_ls) begin
      proc2mem_command = ls_read_write ? CMD_LOAD : CMD_STORE;
      proc2mem_addr    = ls_addr;
      proc2mem_data    = ls_wdata;
      proc2mem_size    = ls_size;
    end
  end

  // Returning data is claimed only by a requester whose load is pending under that tag.
  always_comb begin
    ls_ret = ls_pend && (mem2proc_tag != '0) && (mem2proc_tag == ls_tag);
    if_ret = if_pend && (mem2proc_tag != '0) && (mem2proc_tag == if_tag);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ls_pend  <= 1'b0;
      if_pend  <= 1'b0;
      ls_tag   <= '0;
      if_tag   <= '0;
      streak   <= '0;
      ls_done  <= 1'b0;
      if_done  <= 1'b0;
      ls_rdata <= '0;
      if_rdata <= '0;
    end else begin
      // Stores complete on acceptance and survive a flush; load returns do not.
      ls_done  <= (ls_grant && !ls_read_write) || (ls_ret && !flush);
      ls_rdata <= (ls_ret && !flush) ? mem2proc_data : '0;
      if_done  <= if_ret && !flush;
      if_rdata <= (if_ret && !flush) ? mem2proc_data : '0;

      if (flush) begin
        ls_pend <= 1'b0;
        if_pend <= 1'b0;
        ls_tag  <= '0;
        if_tag  <= '0;
        streak  <= '0;
      end else begin
        if (ls_grant && ls_read_write) begin
          ls_pend <= 1'b1;
          ls_tag  <= mem2proc_response;
        end else if (ls_ret) begin
          ls_pend <= 1'b0;
          ls_tag  <= '0;
        end

        if (if_grant) begin
          if_pend <= 1'b1;
          if_tag  <= mem2proc_response;
        end else if (if_ret) begin
          if_pend <= 1'b0;
          if_tag  <= '0;
        end

        // Count LS wins that kept a ready fetch waiting.
        if (!if_req || if_grant) begin
          streak <= '0;
        end else if (ls_grant && !if_pend && streak != STREAK_W'(STARVE_LIMIT)) begin
          streak <= streak + STREAK_W'(1);
        end
      end
    end
  end

endmodule
